// File: rtl/game_pkg.sv
// Shared game constants: screen size, ship geometry and display colour codes.
// Imported by every block that draws to, or reasons about, the playfield.
package game_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    localparam int SHIP_WIDTH  = 32;
    localparam int SHIP_HEIGHT = 30;
    localparam int V_OFFSET    = 10;
    localparam int H_OFFSET    = 16;

    typedef logic [2:0] color_t;

    localparam color_t BACKGROUND = 3'd0;
    localparam color_t SPACESHIP  = 3'd1;
    localparam color_t ALIENS0    = 3'd2;
    localparam color_t ALIENS1    = 3'd3;
    localparam color_t ALIENS2    = 3'd4;
    localparam color_t ALIENS3    = 3'd5;
    localparam color_t LASER      = 3'd6;
    localparam color_t NONE       = 3'd7;

endpackage

// File: rtl/rise_edge_detect.sv
// Level-to-pulse converter: pulse is high for the cycle a level first rises.
// RESET_VALUE=1 suppresses a pulse for a level already high at reset release.
module rise_edge_detect #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_VALUE;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/laser_shot.sv
// Player laser: launches from the ship nose, climbs once per frame,
// dies on an alien hit or at the top edge, then waits out a cooldown.
module laser_shot
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH    = game_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT   = game_pkg::SCREEN_HEIGHT,
    parameter int SHIP_HEIGHT     = game_pkg::SHIP_HEIGHT,
    parameter int V_OFFSET        = game_pkg::V_OFFSET,
    parameter int LASER_WIDTH     = 2,
    parameter int LASER_HEIGHT    = 12,
    parameter int SPEED           = 8,
    parameter int COOLDOWN_FRAMES = 4,
    localparam int PW             = $clog2(SCREEN_WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fire,
    input  logic          frame_tick,
    input  logic [PW-1:0] gun_position,
    input  logic          hit,
    input  logic [PW-1:0] h_pos,
    input  logic [PW-1:0] v_pos,
    output logic [PW-1:0] laser_x,
    output logic [PW-1:0] laser_y,
    output logic          laser_active,
    output color_t        color
);

    localparam int EW = PW + 1;
    localparam int START_Y =
        SCREEN_HEIGHT - SHIP_HEIGHT - V_OFFSET - LASER_HEIGHT;
    localparam int CW =
        (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOLDOWN
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] x_n, y_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          launch;
    logic          done;
    color_t        color_n;

    logic [EW-1:0] h_ext, v_ext, x_ext, y_ext;
    logic          in_x, in_y;

    rise_edge_detect #(
        .RESET_VALUE(1'b1)
    ) u_fire_edge (
        .clk  (clk),
        .reset(reset),
        .level(fire),
        .pulse(launch)
    );

    assign done = hit | (frame_tick & (laser_y < PW'(SPEED)));

    always_comb begin
        state_n = state;
        x_n     = laser_x;
        y_n     = laser_y;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_n = FLYING;
                    x_n     = gun_position;
                    y_n     = PW'(START_Y);
                end
            end
            FLYING: begin
                if (done) begin
                    state_n = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                    cnt_n   = CW'(COOLDOWN_FRAMES);
                end else if (frame_tick) begin
                    y_n = laser_y - PW'(SPEED);
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    cnt_n = cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Offsets go on the pixel side so nothing near x=0 or y=0 can underflow.
    always_comb begin
        h_ext   = {1'b0, h_pos} + EW'(LASER_WIDTH / 2);
        v_ext   = {1'b0, v_pos};
        x_ext   = {1'b0, laser_x};
        y_ext   = {1'b0, laser_y};
        in_x    = (h_ext >= x_ext) && (h_ext < x_ext + EW'(LASER_WIDTH));
        in_y    = (v_ext >= y_ext) && (v_ext < y_ext + EW'(LASER_HEIGHT));
        color_n = (laser_active && in_x && in_y) ? LASER : NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            laser_x      <= '0;
            laser_y      <= '0;
            cnt          <= '0;
            laser_active <= 1'b0;
            color        <= NONE;
        end else begin
            state        <= state_n;
            laser_x      <= x_n;
            laser_y      <= y_n;
            cnt          <= cnt_n;
            laser_active <= (state_n == FLYING);
            color        <= color_n;
        end
    end

endmodule

// File: tb/tb_laser_shot.sv
// Bench for laser_shot: frame-level reference model checked every cycle,
// plus directed launch, exit, cooldown, hit, render and reset scenarios.
module tb_laser_shot;

    localparam int LW      = 2;
    localparam int LH      = 12;
    localparam int SPEED   = 8;
    localparam int COOL    = 4;
    localparam int START_Y = 428;

    logic       clk = 1'b0;
    logic       reset;
    logic       fire;
    logic       frame_tick;
    logic [9:0] gun_position;
    logic       hit;
    logic [9:0] h_pos;
    logic [9:0] v_pos;
    logic [9:0] laser_x;
    logic [9:0] laser_y;
    logic       laser_active;
    logic [2:0] color;

    int n_checks = 0;
    int n_fail   = 0;

    laser_shot dut (
        .clk         (clk),
        .reset       (reset),
        .fire        (fire),
        .frame_tick  (frame_tick),
        .gun_position(gun_position),
        .hit         (hit),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .laser_x     (laser_x),
        .laser_y     (laser_y),
        .laser_active(laser_active),
        .color       (color)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: one shot in flight, or a count of frames to wait.
    bit m_fly  = 1'b0;
    int m_x    = 0;
    int m_y    = 0;
    int m_cool = 0;
    bit m_fq   = 1'b1;
    int m_col  = 7;

    always @(posedge clk) begin
        if (reset) begin
            m_fly  <= 1'b0;
            m_x    <= 0;
            m_y    <= 0;
            m_cool <= 0;
            m_fq   <= 1'b1;
            m_col  <= 7;
        end else begin
            m_col <= (m_fly
                      && int'(h_pos) >= m_x - LW / 2
                      && int'(h_pos) <  m_x + LW / 2
                      && int'(v_pos) >= m_y
                      && int'(v_pos) <  m_y + LH) ? 6 : 7;
            m_fq <= fire;
            if (m_fly) begin
                if (hit || (frame_tick && m_y < SPEED)) begin
                    m_fly  <= 1'b0;
                    m_cool <= COOL;
                end else if (frame_tick) begin
                    m_y <= m_y - SPEED;
                end
            end else if (m_cool > 0) begin
                if (frame_tick) m_cool <= m_cool - 1;
            end else if (fire && !m_fq) begin
                m_fly <= 1'b1;
                m_x   <= int'(gun_position);
                m_y   <= START_Y;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_active", int'(laser_active), int'(m_fly));
        chk("model_x", int'(laser_x), m_x);
        chk("model_y", int'(laser_y), m_y);
        chk("model_color", int'(color), m_col);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic press();
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        fire         = 1'b0;
        frame_tick   = 1'b0;
        gun_position = 10'd0;
        hit          = 1'b0;
        h_pos        = 10'd0;
        v_pos        = 10'd0;
        step(3);
        reset = 1'b0;
        chk("rst_active", int'(laser_active), 0);
        chk("rst_x", int'(laser_x), 0);
        chk("rst_y", int'(laser_y), 0);
        chk("rst_color", int'(color), 7);
        step(1);

        // Launch from the gun
        gun_position = 10'd320;
        press();
        chk("launch_active", int'(laser_active), 1);
        chk("launch_x", int'(laser_x), 320);
        chk("launch_y", int'(laser_y), 428);
        gun_position = 10'd100;

        // Render around (320, 428)
        h_pos = 10'd319; v_pos = 10'd428;
        step(1);
        chk("px_319_428", int'(color), 6);
        h_pos = 10'd321;
        step(1);
        chk("px_321_428", int'(color), 7);
        h_pos = 10'd320; v_pos = 10'd439;
        step(1);
        chk("px_320_439", int'(color), 6);
        h_pos = 10'd319; v_pos = 10'd440;
        step(1);
        chk("px_319_440", int'(color), 7);
        h_pos = 10'd318; v_pos = 10'd428;
        step(1);
        chk("px_318_428", int'(color), 7);

        tick();
        chk("tick1_y", int'(laser_y), 420);
        chk("tick1_x_held", int'(laser_x), 320);

        // Climb to the top edge and leave
        repeat (52) tick();
        chk("tick53_y", int'(laser_y), 4);
        chk("tick53_active", int'(laser_active), 1);
        tick();
        chk("exit_active", int'(laser_active), 0);

        // Fire edges during cooldown, including on the last tick, are dropped
        gun_position = 10'd200;
        for (int i = 0; i < COOL; i++) begin
            fire       = 1'b1;
            frame_tick = 1'b1;
            @(negedge clk);
            fire       = 1'b0;
            frame_tick = 1'b0;
            chk("cool_no_launch", int'(laser_active), 0);
            step(1);
            chk("cool_no_launch2", int'(laser_active), 0);
        end
        press();
        chk("post_cool_launch", int'(laser_active), 1);
        chk("post_cool_x", int'(laser_x), 200);

        // Hit at y=300 together with a tick and a fire edge
        repeat (16) tick();
        chk("pre_hit_y", int'(laser_y), 300);
        hit        = 1'b1;
        frame_tick = 1'b1;
        fire       = 1'b1;
        @(negedge clk);
        hit        = 1'b0;
        frame_tick = 1'b0;
        fire       = 1'b0;
        chk("hit_active", int'(laser_active), 0);
        chk("hit_y_held", int'(laser_y), 300);
        step(1);
        chk("hit_fire_ignored", int'(laser_active), 0);
        repeat (COOL) tick();

        // Idle: no pixel is laser-coloured, even at the old spot
        h_pos = 10'd200; v_pos = 10'd300;
        step(1);
        chk("idle_px_a", int'(color), 7);
        h_pos = 10'd199; v_pos = 10'd305;
        step(1);
        chk("idle_px_b", int'(color), 7);

        // Button held through reset does not fire
        fire  = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        chk("hold_no_launch", int'(laser_active), 0);
        fire = 1'b0;
        step(1);
        gun_position = 10'd50;
        press();
        chk("repress_launch", int'(laser_active), 1);
        chk("repress_x", int'(laser_x), 50);

        // Reset in flight
        h_pos = 10'd50; v_pos = 10'd430;
        step(1);
        chk("flight_px", int'(color), 6);
        reset = 1'b1;
        step(1);
        chk("rst_flight_active", int'(laser_active), 0);
        chk("rst_flight_color", int'(color), 7);
        chk("rst_flight_y", int'(laser_y), 0);
        reset = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
